// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit frame controller.
//   - tx_state_e       : frame controller FSM states
//   - PAR_EVEN/PAR_ODD : encodings of the parity-type select
//   - DefaultDataWidth : default frame payload width
package uart_tx_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } tx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int unsigned DefaultDataWidth = 8;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Bundle of the host-side, serializer-side and line-side signals of uart_tx_ctrl.
//   slave  : the frame controller (consumes host/serializer inputs, drives line/status)
//   master : the environment (host plus serializer) around the controller
//   P_DATA/Data_Valid/PAR_EN/PAR_TYP : host byte, strobe and parity config
//   ser_data/ser_done                : serializer bit stream and last-bit flag
//   ser_en/ser_p_data                : serializer load pulse and latched byte
//   TX_OUT/busy/frame_err            : serial line, frame-in-progress, sticky error
interface uart_tx_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  ser_data;
    logic                  ser_done;
    logic                  ser_en;
    logic [DATA_WIDTH-1:0] ser_p_data;
    logic                  TX_OUT;
    logic                  busy;
    logic                  frame_err;

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_data, ser_done,
        output ser_en, ser_p_data, TX_OUT, busy, frame_err
    );

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_data, ser_done,
        input  ser_en, ser_p_data, TX_OUT, busy, frame_err
    );
endinterface

// File: rtl/parity_calc.sv
// Combinational parity generator for the transmit frame.
//   data_i    : latched frame payload
//   par_typ_i : PAR_EVEN or PAR_ODD
//   parity_o  : parity bit to place on the line
module parity_calc
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefaultDataWidth
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  par_typ_i,
    output logic                  parity_o
);

    always_comb begin
        parity_o = (par_typ_i == PAR_ODD) ? ~(^data_i) : ^data_i;
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller, one clock per bit.
// Accepts a host byte, loads the external serializer, and muxes start, data,
// optional parity and stop bits onto the registered serial line.
//   CLK : bit-rate clock
//   RST : asynchronous active-low reset
//   bus : uart_tx_ctrl_if slave modport (host, serializer and line signals)
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefaultDataWidth
) (
    input  logic           CLK,
    input  logic           RST,
    uart_tx_ctrl_if.slave  bus
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);

    tx_state_e             state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  err_q, err_d;
    logic                  tx_q, tx_d;
    logic                  ser_en;
    logic                  par_bit;
    logic                  cnt_last;

    parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity_calc (
        .data_i    (data_q),
        .par_typ_i (par_typ_q),
        .parity_o  (par_bit)
    );

    assign cnt_last = (cnt_q == CntW'(DATA_WIDTH - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        err_d     = err_q;
        tx_d      = 1'b1;
        ser_en    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.Data_Valid) begin
                    data_d    = bus.P_DATA;
                    par_en_d  = bus.PAR_EN;
                    par_typ_d = bus.PAR_TYP;
                    err_d     = 1'b0;
                    state_d   = StStart;
                end
            end
            StStart: begin
                tx_d    = 1'b0;
                ser_en  = 1'b1;
                cnt_d   = '0;
                state_d = StData;
            end
            StData: begin
                tx_d  = bus.ser_data;
                cnt_d = cnt_q + 1'b1;
                // Leave on whichever comes first; disagreement between the
                // serializer's done flag and our own count is a protocol error.
                if (bus.ser_done || cnt_last) begin
                    if (bus.ser_done != cnt_last) begin
                        err_d = 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = par_en_q ? StParity : StStop;
                end
            end
            StParity: begin
                tx_d    = par_bit;
                state_d = StStop;
            end
            StStop: begin
                tx_d    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= PAR_EVEN;
            err_q     <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            err_q     <= err_d;
            tx_q      <= tx_d;
        end
    end

    assign bus.ser_en     = ser_en;
    assign bus.ser_p_data = data_q;
    assign bus.TX_OUT     = tx_q;
    assign bus.busy       = (state_q != StIdle);
    assign bus.frame_err  = err_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed self-checking bench for uart_tx_ctrl with a behavioural serializer.
module tb_uart_tx_ctrl;

    logic clk;
    logic rst_n;

    int n_cmp  = 0;
    int n_fail = 0;

    // Serializer model: 0 = normal, 1 = never asserts done, 2 = done early
    int       ser_mode = 0;
    logic [7:0] ser_sh;
    int       ser_idx;
    logic     ser_act;

    uart_tx_ctrl_if #(.DATA_WIDTH(8)) bus ();

    uart_tx_ctrl #(
        .DATA_WIDTH (8)
    ) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.ser_en) begin
            ser_sh  <= bus.ser_p_data;
            ser_idx <= 0;
            ser_act <= 1'b1;
        end else if (ser_act) begin
            ser_sh  <= ser_sh >> 1;
            ser_idx <= ser_idx + 1;
            if (ser_idx == 7) ser_act <= 1'b0;
        end
    end

    assign bus.ser_data = ser_act ? ser_sh[0] : 1'b0;
    assign bus.ser_done = ser_act &&
                          ((ser_mode == 0 && ser_idx == 7) || (ser_mode == 2 && ser_idx == 3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends one frame and checks the line bit by bit. seq is written in
    // transmission order left to right (seq[n-1] is the start bit).
    task automatic send(input string tag, input logic [7:0] d, input logic pe, input logic pt,
                        input int n, input logic [10:0] seq, input logic exp_err,
                        input int inject_at);
        bus.P_DATA     = d;
        bus.PAR_EN     = pe;
        bus.PAR_TYP    = pt;
        bus.Data_Valid = 1'b1;
        step();
        bus.Data_Valid = 1'b0;
        chk({tag, " busy@accept"}, 32'(bus.busy), 32'd1);
        chk({tag, " ser_en@start"}, 32'(bus.ser_en), 32'd1);
        for (int j = 0; j < n; j++) begin
            step();
            bus.Data_Valid = 1'b0;
            bus.P_DATA     = d;
            chk($sformatf("%s bit%0d", tag, j), 32'(bus.TX_OUT), 32'(seq[n-1-j]));
            chk($sformatf("%s busy%0d", tag, j), 32'(bus.busy), (j < n - 1) ? 32'd1 : 32'd0);
            if (j == inject_at) begin
                bus.P_DATA     = 8'h00;
                bus.Data_Valid = 1'b1;
            end
        end
        chk({tag, " frame_err"}, 32'(bus.frame_err), 32'(exp_err));
        chk({tag, " ser_p_data"}, 32'(bus.ser_p_data), 32'(d));
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.P_DATA     = 8'h00;
        bus.Data_Valid = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        #12;
        chk("reset tx", 32'(bus.TX_OUT), 32'd1);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset ser_p_data", 32'(bus.ser_p_data), 32'd0);
        chk("reset frame_err", 32'(bus.frame_err), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle tx", 32'(bus.TX_OUT), 32'd1);
            chk("idle busy", 32'(bus.busy), 32'd0);
            chk("idle ser_en", 32'(bus.ser_en), 32'd0);
        end

        send("AD even", 8'hAD, 1'b1, 1'b0, 11, 11'b01011010111, 1'b0, -1);
        send("AD odd", 8'hAD, 1'b1, 1'b1, 11, 11'b01011010101, 1'b0, -1);
        send("AD nopar", 8'hAD, 1'b0, 1'b0, 10, 11'b0101101011, 1'b0, -1);
        // Strobe with 8'h00 while bit 2 is in flight must be dropped
        send("AD drop", 8'hAD, 1'b1, 1'b0, 11, 11'b01011010111, 1'b0, 3);
        step();
        chk("drop stays idle", 32'(bus.busy), 32'd0);

        ser_mode = 1;
        send("no done", 8'hAD, 1'b0, 1'b0, 10, 11'b0101101011, 1'b1, -1);
        ser_mode = 2;
        send("early done", 8'hAD, 1'b0, 1'b0, 6, 11'b010111, 1'b1, -1);
        ser_mode = 0;
        send("err clears", 8'hAD, 1'b1, 1'b0, 11, 11'b01011010111, 1'b0, -1);

        // Reset in the middle of data bit 4
        bus.P_DATA     = 8'hAD;
        bus.PAR_EN     = 1'b1;
        bus.PAR_TYP    = 1'b0;
        bus.Data_Valid = 1'b1;
        step();
        bus.Data_Valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("pre-reset bit3", 32'(bus.TX_OUT), 32'd1);
        step();
        chk("pre-reset bit4 busy", 32'(bus.busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset tx", 32'(bus.TX_OUT), 32'd1);
        chk("midreset busy", 32'(bus.busy), 32'd0);
        chk("midreset ser_en", 32'(bus.ser_en), 32'd0);
        chk("midreset ser_p_data", 32'(bus.ser_p_data), 32'd0);
        #3;
        rst_n = 1'b1;
        step();
        step();
        chk("post-reset idle", 32'(bus.TX_OUT), 32'd1);
        chk("post-reset busy", 32'(bus.busy), 32'd0);

        send("5A even", 8'h5A, 1'b1, 1'b0, 11, 11'b00101101001, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Frame controller for the UART transmitter. Accepts a parallel byte from the host with a valid strobe, drives the existing serializer through its `ser_en`/`ser_done` handshake, computes the optional parity bit, and muxes start, data, parity and stop bits onto the registered serial line `TX_OUT`. Runs at one clock per bit (bit-rate clock) and sits between the host interface and the UART line, alongside the serializer.

## Interface
- `DATA_WIDTH`, default 8: frame payload width. Must match the serializer.
- `CLK`  in  1  bit-rate clock; all state changes on the rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `P_DATA`  in  DATA_WIDTH  byte from the host; sampled only on acceptance.
- `Data_Valid`  in  1  host strobe; accepted only when `busy`=0.
- `PAR_EN`  in  1  1 = insert a parity bit; sampled on acceptance.
- `PAR_TYP`  in  1  0 = even, 1 = odd; sampled on acceptance.
- `ser_data`  in  1  current bit from the serializer.
- `ser_done`  in  1  serializer flag for the last data bit.
- `ser_en`  out  1  one-cycle load pulse to the serializer.
- `ser_p_data`  out  DATA_WIDTH  latched byte presented to the serializer.
- `TX_OUT`  out  1  serial line. Idle is high.
- `busy`  out  1  frame in progress.
- `frame_err`  out  1  sticky flag for a serializer protocol violation.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. The encoding is defined in the package.
- **IDLE:** if `Data_Valid`=1, latch `P_DATA`, `PAR_EN` and `PAR_TYP`, clear `frame_err`, and go to START.
- **START:** line mux = 0. `ser_en`=1 for this single cycle. Go to DATA next cycle.
- **DATA:** line mux = `ser_data`. The bit counter increments each cycle.
  - On `ser_done`=1, go to PARITY if the latched `PAR_EN`=1, else go to STOP.
  - If the counter reaches DATA_WIDTH without `ser_done`, set `frame_err` and force the PARITY/STOP transition anyway.
  - If `ser_done` arrives before the count reaches DATA_WIDTH, set `frame_err` and exit the same way.
- **PARITY:** line mux = parity bit.
  - Even parity: bit = XOR-reduce of the latched data.
  - Odd parity: bit = inverted XOR-reduce of the latched data.
  - Go to STOP.
- **STOP:** line mux = 1. Go to IDLE. `Data_Valid` is ignored here, so there is at least one IDLE cycle between frames.
- `busy` = 1 in every state except IDLE. It is a Moore output.
- `Data_Valid` while `busy`=1 is dropped, not queued.
- `ser_p_data` holds the latched byte from acceptance until the next acceptance.
- Reset (any time, including mid-frame):
  - state = IDLE
  - `TX_OUT`=1, `busy`=0, `ser_en`=0, `frame_err`=0
  - `ser_p_data`=0, bit counter = 0
- Nothing resumes after reset; the partial frame is abandoned.

## Timing
- Serializer contract: the load happens on the edge where `ser_en`=1.
  - Bit 0 (LSB) is valid on `ser_data` in the following cycle.
  - Bit i is valid i cycles after that.
  - `ser_done`=1 in the same cycle as bit DATA_WIDTH-1.
- Acceptance edge k (IDLE, `Data_Valid`=1):
  - START occupies cycle k..k+1; `ser_en`=1 in that cycle.
  - DATA occupies DATA_WIDTH cycles.
  - Then PARITY (if enabled), then STOP.
- `TX_OUT` is a register loaded from the line mux, so it lags state by one cycle.
  - Start bit on `TX_OUT` from edge k+1.
  - Each bit is exactly one clock wide.
- Frame length on `TX_OUT`:
  - DATA_WIDTH+3 = 11 cycles with parity.
  - DATA_WIDTH+2 = 10 cycles without parity.
- `busy` rises at edge k and falls at the edge leaving STOP.
- Minimum acceptance spacing: 12 cycles with parity, 11 without.

## Structure
- Package `uart_tx_pkg`:
  - state enum/localparams
  - `PAR_EVEN`/`PAR_ODD` constants
  - default `DATA_WIDTH`
- Sub-module `parity_calc`:
  - Combinational.
  - Inputs: latched data and `PAR_TYP`.
  - Output: parity bit.
- The FSM, bit counter, data latch and output register stay in `uart_tx_ctrl`.
- The serializer is instantiated beside this block by the UART_TX top, not inside it.

## Test plan
- Reset, then idle for 5 cycles -> `TX_OUT`=1, `busy`=0, `ser_en` never pulses.
- `P_DATA`=8'hAD, `PAR_EN`=1, `PAR_TYP`=0 with a behavioural serializer:
  - `TX_OUT` sequence 0,1,0,1,1,0,1,0,1,1,1 (start, LSB-first data, parity 1, stop).
  - `busy` high 11 cycles, `frame_err`=0.
- Same byte with `PAR_TYP`=1 -> parity bit 0.
- Same byte with `PAR_EN`=0 -> 10-bit frame ending 0,1,0,1,1,0,1,0,1,1, no parity slot.
- `Data_Valid` pulsed at the third data bit with `P_DATA`=8'h00 -> ignored; the frame for 8'hAD completes unchanged.
- Serializer model that never asserts `ser_done` -> exit DATA after 8 cycles and `frame_err`=1.
- Serializer model that asserts `ser_done` early -> `frame_err`=1.
- Assert `RST`=0 during bit 4 -> immediately `TX_OUT`=1, `busy`=0.
- After release, a new 8'h5A frame with `PAR_EN`=1, `PAR_TYP`=0 transmits correctly with parity 0.
